dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory (datamem) between two requesters: port 0 is the CPU load/store path, port 1 is the debug/DMA path.
- Per-port request/grant/response handshake, 2-way round-robin arbitration, transfer size/alignment checking.
- Sequences each memory access over a fixed, parameterised latency.
- Sits between the execute/memory stage and datamem, replacing the direct ALU-result-to-address hookup.

Parameters:
LATENCY, 1, memory access cycles per transaction; legal values 1..15.
ADDR_W, 64, address width.
DATA_W, 64, data width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  [1:0]  per-port request; held high until that port's gnt is seen.
we  in  [1:0]  per-port write (1) / read (0).
addr  in  [1:0][ADDR_W-1:0]  per-port byte address.
wdata  in  [1:0][DATA_W-1:0]  per-port write data.
size  in  [1:0][3:0]  per-port transfer size in bytes; legal values 1, 2, 4, 8.
gnt  out  [1:0]  one-cycle pulse: request accepted.
rvalid  out  [1:0]  one-cycle pulse: transaction complete (reads and writes).
rdata  out  DATA_W  read data; valid only while some rvalid bit is high.
err  out  1  qualifies rvalid: illegal size or misaligned address.
mem_address  out  ADDR_W  to datamem address.
mem_write_enable  out  1  to datamem write_enable.
mem_read_enable  out  1  to datamem read_enable.
mem_write_data  out  DATA_W  to datamem write_data.
mem_xfer_size  out  4  to datamem xfer_size.
mem_read_data  in  DATA_W  from datamem read_data.

Behaviour:
- Reset (reset=0) forces, asynchronously:
  - state=IDLE, last_grant=1, count=0, rdata=0;
  - every output = 0.
- States: IDLE, ACCESS, RESP.
- IDLE, at an edge with req != 0:
  - winner = sole requester if only one requests; otherwise the port != last_grant.
  - Latch the winner's we/addr/wdata/size and set last_grant=winner.
  - Compute the error condition: size not in {1,2,4,8}, or addr mod size != 0.
  - No error: next state ACCESS, count=LATENCY-1. Error: next state RESP.
- gnt[winner]=1 for exactly the first cycle after acceptance (the first ACCESS cycle, or the RESP cycle on error).
  - The requester drops req after seeing gnt.
  - req is ignored outside IDLE.
- ACCESS:
  - mem_address, mem_write_data and mem_xfer_size are driven from the latched values for every ACCESS cycle.
  - mem_read_enable=1 for all ACCESS cycles of a read.
  - mem_write_enable=1 only in the first ACCESS cycle of a write, so exactly one write occurs.
  - count decrements each cycle. At the edge with count=0: rdata <= mem_read_data for reads, 0 for writes; next state RESP.
- RESP, one cycle:
  - rvalid[winner]=1; err=1 if the error condition held; rdata=0 on error.
  - Next state IDLE.
- All mem_* outputs are 0 outside ACCESS; on error, no memory enable is ever asserted.
- Latency:
  - Accepted at edge 0: gnt in cycle 1, rvalid in cycle LATENCY+1.
  - Error path: rvalid in cycle 1.
  - IDLE is revisited in cycle LATENCY+2.
  - Throughput: one transaction per LATENCY+2 cycles.
- A request arriving while busy waits in IDLE.
- With continuous requests from both ports, grants strictly alternate; no starvation.
- Reset mid-transaction:
  - The transaction is dropped; no gnt/rvalid is ever produced for it.
  - A write already issued to memory is not undone.
  - The requester must re-issue after reset.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - size constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8;
  - function size_ok(size, addr) returning the legal-and-aligned check.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from (req, last_grant), outputs winner and any_req.
- dmem_arbiter holds the FSM, latches, counter and response registers.

Test Plan:
- LATENCY=2, memory word at 0x10 preloaded with 0x1122334455667788; req=01, we0=0, addr0=0x10, size0=8 ->
  - gnt0 in cycle 1;
  - mem_read_enable=1 in cycles 1-2;
  - rvalid0=1, err=0, rdata=0x1122334455667788 in cycle 3.
- Port 1 write, addr=0x20, wdata=0xDEADBEEFCAFEF00D, size=8, LATENCY=1 ->
  - mem_write_enable=1 for exactly one cycle;
  - rvalid1 in cycle 2, rdata=0;
  - subsequent port 0 read of 0x20 returns 0xDEADBEEFCAFEF00D.
- req=11 held continuously from reset release, each port re-raising req after its rvalid -> grant order 0,1,0,1; never the same port twice in a row.
- Port 0 request, addr=0x13, size=4 ->
  - gnt0 and rvalid0 in cycle 1, err=1, rdata=0;
  - mem_read_enable and mem_write_enable stay 0 throughout.
- Port 1 request with size=3 -> err=1 with rvalid1; then a legal size=2 request at 0x02 completes with err=0.
- LATENCY=4; assert reset during the second ACCESS cycle ->
  - all outputs 0 within the same cycle; no rvalid after release;
  - last_grant=1, so the next simultaneous request is granted to port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   state_t  : arbiter FSM states (IDLE, ACCESS, RESP)
//   SZ_*     : legal transfer sizes in bytes
//   CNT_W    : width of the access-latency counter (LATENCY up to 15)
//   size_ok  : legal-size and natural-alignment check for one request
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  localparam int CNT_W = 4;

  // Only the low three address bits matter: the largest legal size is 8 bytes,
  // so "addr mod size == 0" never depends on higher bits.
  function automatic logic size_ok(input logic [3:0] size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0]   == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      SZ_D:    ok = (addr_lo      == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   i_req        : per-port request
//   i_last_grant : port that won the previous arbitration
//   o_winner     : selected port (meaningful only when o_any_req is high)
//   o_any_req    : at least one port is requesting
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_any_req
);

  always_comb begin
    o_any_req = |i_req;
    case (i_req)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      // Contention: the port that did not win last time goes first.
      default: o_winner = ~i_last_grant;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data memory between the CPU load/store path (port 0) and the
// debug/DMA path (port 1). One transaction in flight at a time; each access
// is held on the memory interface for LATENCY cycles.
//
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req/i_we/i_addr/
//   i_wdata/i_size          : per-port request (held until o_gnt for that port)
//   o_gnt                   : one-cycle pulse, request accepted
//   o_rvalid                : one-cycle pulse, transaction complete
//   o_rdata, o_err          : response data / error flag, qualified by o_rvalid
//   o_mem_*                 : datamem address, enables, write data, size
//   i_mem_read_data         : datamem read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_req,
  input  logic [1:0]             i_we,
  input  logic [1:0][ADDR_W-1:0] i_addr,
  input  logic [1:0][DATA_W-1:0] i_wdata,
  input  logic [1:0][3:0]        i_size,
  output logic [1:0]             o_gnt,
  output logic [1:0]             o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_err,
  output logic [ADDR_W-1:0]      o_mem_address,
  output logic                   o_mem_write_enable,
  output logic                   o_mem_read_enable,
  output logic [DATA_W-1:0]      o_mem_write_data,
  output logic [3:0]             o_mem_xfer_size,
  input  logic [DATA_W-1:0]      i_mem_read_data
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;   // also the owner of the in-flight transaction
  logic [CNT_W-1:0]    r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_size;
  logic                r_err;
  logic                r_first;        // high for the cycle right after acceptance
  logic [DATA_W-1:0]   r_rdata;

  logic                w_winner;
  logic                w_any_req;
  logic                w_accept;
  logic                w_req_err;

  rr_arbiter2 u_rr (
    .i_req        (i_req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

  assign w_accept  = (r_state == IDLE) && w_any_req;
  assign w_req_err = ~size_ok(i_size[w_winner], i_addr[w_winner][2:0]);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next = w_req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (r_count == '0) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latches, latency counter and response data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_err        <= 1'b0;
      r_first      <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_first <= w_accept;
      if (w_accept) begin
        r_last_grant <= w_winner;
        r_we         <= i_we[w_winner];
        r_addr       <= i_addr[w_winner];
        r_wdata      <= i_wdata[w_winner];
        r_size       <= i_size[w_winner];
        r_err        <= w_req_err;
        r_count      <= CNT_INIT;
        r_rdata      <= '0;
      end else if (r_state == ACCESS) begin
        if (r_count == '0) begin
          r_rdata <= r_we ? '0 : i_mem_read_data;
        end else begin
          r_count <= r_count - 1'b1;
        end
      end else if (r_state == RESP) begin
        r_rdata <= '0;
      end
    end
  end

  // Output logic: memory interface is live only in ACCESS
  always_comb begin
    o_mem_address      = '0;
    o_mem_write_enable = 1'b0;
    o_mem_read_enable  = 1'b0;
    o_mem_write_data   = '0;
    o_mem_xfer_size    = '0;
    o_err              = 1'b0;
    case (r_state)
      ACCESS: begin
        o_mem_address      = r_addr;
        o_mem_write_data   = r_wdata;
        o_mem_xfer_size    = r_size;
        o_mem_read_enable  = ~r_we;
        // Write strobe only on the first access cycle so memory sees one write.
        o_mem_write_enable = r_we & r_first;
      end
      RESP: begin
        o_err = r_err;
      end
      default: begin
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign o_gnt[gi]    = r_first && (r_last_grant == 1'(gi));
      assign o_rvalid[gi] = (r_state == RESP) && (r_last_grant == 1'(gi));
    end
  endgenerate

  assign o_rdata = r_rdata;

endmodule
